// File: rtl/pot_shift_mac.sv
// Power-of-two weight MAC: per-lane sign/shift products, adder tree, accumulator with valid/ready I/O.
// Optional macro POT_SHIFT_MAC_SATURATE_EN clamps the accumulator and reports a sticky overflow.
`timescale 1ns/1ps
module pot_shift_mac #(
    parameter int unsigned WEIGHT_BIT_WIDTH = 4,
    parameter int unsigned INPUT_BIT_WIDTH  = 4,
    parameter int unsigned LANES            = 4,
    parameter int unsigned ACC_BIT_WIDTH    = 20
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES*INPUT_BIT_WIDTH-1:0]    in_data,
    input  logic [LANES*WEIGHT_BIT_WIDTH-1:0]   in_weight,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ACC_BIT_WIDTH-1:0]            out_data,
    output logic [15:0]                         out_beats,
    output logic                                out_overflow
);

    localparam int unsigned SHIFT_W        = WEIGHT_BIT_WIDTH - 1;
    localparam int unsigned PROD_BIT_WIDTH = INPUT_BIT_WIDTH + (2**WEIGHT_BIT_WIDTH) / 2;
    localparam int unsigned TREE_W         = PROD_BIT_WIDTH + $clog2(LANES);
    localparam int unsigned EXT_W          = ((TREE_W > ACC_BIT_WIDTH) ? TREE_W : ACC_BIT_WIDTH) + 1;

    localparam logic signed [EXT_W-1:0] ACC_MAX =
        {{(EXT_W - ACC_BIT_WIDTH + 1){1'b0}}, {(ACC_BIT_WIDTH - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN =
        {{(EXT_W - ACC_BIT_WIDTH + 1){1'b1}}, {(ACC_BIT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                              r_drain_cnt;
    logic                              r_in_ready;
    logic                              r_out_valid;
    logic signed [ACC_BIT_WIDTH-1:0]   r_out_data;
    logic [15:0]                       r_out_beats;
    logic                              r_out_ovf;

    logic signed [PROD_BIT_WIDTH-1:0]  r_prod [LANES];
    logic                              r_s1_valid;
    logic                              r_s1_first;
    logic signed [ACC_BIT_WIDTH-1:0]   r_acc;
    logic [15:0]                       r_beats;
    logic                              r_ovf;

    logic                              w_accept;
    logic                              w_out_fire;
    logic signed [PROD_BIT_WIDTH-1:0]  w_prod [LANES];
    logic signed [EXT_W-1:0]           w_tree_sum;
    logic signed [EXT_W-1:0]           w_acc_base;
    logic signed [EXT_W-1:0]           w_acc_wide;
    logic signed [ACC_BIT_WIDTH-1:0]   w_acc_next;
    logic                              w_ovf_beat;

    assign w_accept     = in_valid && r_in_ready;
    assign w_out_fire   = r_out_valid && out_ready;
    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_beats    = r_out_beats;
    assign out_overflow = r_out_ovf;

    // Per-lane product: optionally negated activation shifted by the weight's low bits.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [PROD_BIT_WIDTH-1:0] w_mag;
        logic                      w_sign;
        logic [SHIFT_W-1:0]        w_shift;

        assign w_mag     = PROD_BIT_WIDTH'(in_data[g*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH]);
        assign w_sign    = in_weight[g*WEIGHT_BIT_WIDTH + WEIGHT_BIT_WIDTH - 1];
        assign w_shift   = in_weight[g*WEIGHT_BIT_WIDTH +: SHIFT_W];
        assign w_prod[g] = w_sign ? ((-w_mag) << w_shift) : (w_mag << w_shift);
    end

    // Stage-2 sum is kept wide so saturation can see the true value before truncation.
    always_comb begin
        w_tree_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_tree_sum = w_tree_sum + EXT_W'(r_prod[l]);
        end
        if (r_s1_first) begin
            w_acc_base = '0;
        end else begin
            w_acc_base = EXT_W'(r_acc);
        end
        w_acc_wide = w_acc_base + w_tree_sum;
`ifdef POT_SHIFT_MAC_SATURATE_EN
        if (w_acc_wide > ACC_MAX) begin
            w_acc_next = ACC_BIT_WIDTH'(ACC_MAX);
            w_ovf_beat = 1'b1;
        end else if (w_acc_wide < ACC_MIN) begin
            w_acc_next = ACC_BIT_WIDTH'(ACC_MIN);
            w_ovf_beat = 1'b1;
        end else begin
            w_acc_next = ACC_BIT_WIDTH'(w_acc_wide);
            w_ovf_beat = 1'b0;
        end
`else
        w_acc_next = ACC_BIT_WIDTH'(w_acc_wide);
        w_ovf_beat = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    w_state_next = in_last ? S_DRAIN : S_ACCUM;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt) begin
                    w_state_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (w_out_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control and result registers; results are captured once the accumulator has settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_beats <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_drain_cnt <= (r_state == S_DRAIN) ? (r_drain_cnt + 1'b1) : 1'b0;
            r_in_ready  <= (w_state_next == S_IDLE) || (w_state_next == S_ACCUM);
            r_out_valid <= (r_state == S_OUTPUT) && !w_out_fire;
            if ((r_state == S_OUTPUT) && !r_out_valid) begin
                r_out_data  <= r_acc;
                r_out_beats <= r_beats;
                r_out_ovf   <= r_ovf;
            end
        end
    end

    // Datapath: stage 1 captures products, stage 2 folds their sum into the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                r_prod[l] <= '0;
            end
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_acc      <= '0;
            r_beats    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                for (int l = 0; l < LANES; l++) begin
                    r_prod[l] <= w_prod[l];
                end
                r_s1_first <= (r_state == S_IDLE);
                r_beats    <= (r_state == S_IDLE) ? 16'd1 : (r_beats + 16'd1);
            end
            if (r_s1_valid) begin
                r_acc <= w_acc_next;
                r_ovf <= r_s1_first ? w_ovf_beat : (r_ovf | w_ovf_beat);
            end
        end
    end

endmodule

// File: tb/tb_pot_shift_mac.sv
// Directed self-checking bench for pot_shift_mac (2 lanes; 20-bit and 12-bit accumulator instances).
`timescale 1ns/1ps
module tb_pot_shift_mac;

    localparam int unsigned IW    = 4;
    localparam int unsigned WW    = 4;
    localparam int unsigned LANES = 2;
    localparam int unsigned ACC_W = 20;
    localparam int unsigned ACC_S = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   in_valid;
    logic                   in_last;
    logic                   out_ready;
    logic [LANES*IW-1:0]    in_data;
    logic [LANES*WW-1:0]    in_weight;

    logic                   in_ready, out_valid, out_overflow;
    logic [ACC_W-1:0]       out_data;
    logic [15:0]            out_beats;
    logic                   s_in_ready, s_out_valid, s_out_overflow;
    logic [ACC_S-1:0]       s_out_data;
    logic [15:0]            s_out_beats;

    int checks = 0;
    int errors = 0;

    pot_shift_mac #(
        .WEIGHT_BIT_WIDTH(WW), .INPUT_BIT_WIDTH(IW), .LANES(LANES), .ACC_BIT_WIDTH(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_beats(out_beats), .out_overflow(out_overflow)
    );

    pot_shift_mac #(
        .WEIGHT_BIT_WIDTH(WW), .INPUT_BIT_WIDTH(IW), .LANES(LANES), .ACC_BIT_WIDTH(ACC_S)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_beats(s_out_beats), .out_overflow(s_out_overflow)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Present a beat and return just after the edge that accepts it; in_valid is left high.
    task automatic drive_beat(input logic [3:0] a0, input logic [3:0] w0,
                              input logic [3:0] a1, input logic [3:0] w1, input logic last);
        int n;
        in_data   = {a1, a0};
        in_weight = {w1, w0};
        in_last   = last;
        in_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            $fatal(1);
        end
        @(posedge clk);
        #1;
    endtask

    // Count edges from the acceptance edge until out_valid is seen; 99 means it never rose.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) return;
        end
        lat = 99;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_data = '0; in_weight = '0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        checks++; if (out_beats !== 16'd0) begin errors++; $display("FAIL reset_out_beats: got %0d want 0", out_beats); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", out_overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat();
        int lat;
        drive_beat(4'd5, 4'b0011, 4'd5, 4'b1011, 1'b1);
        in_valid = 1'b0;
        wait_valid(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency: got %0d want 3", lat); end
        checks++; if ($signed(out_data) !== 20'sd0) begin errors++; $display("FAIL single_data: got %0d want 0", $signed(out_data)); end
        checks++; if (out_beats !== 16'd1) begin errors++; $display("FAIL single_beats: got %0d want 1", out_beats); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL single_overflow: got %0b want 0", out_overflow); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready: got %0b want 0", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_multi_beat();
        int lat;
        for (int i = 0; i < 3; i++) begin
            drive_beat(4'd15, 4'b0111, 4'd1, 4'b1000, (i == 2));
        end
        in_valid = 1'b0;
        wait_valid(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL multi_latency: got %0d want 3", lat); end
        checks++; if ($signed(out_data) !== 20'sd5757) begin errors++; $display("FAIL multi_data: got %0d want 5757", $signed(out_data)); end
        checks++; if (out_beats !== 16'd3) begin errors++; $display("FAIL multi_beats: got %0d want 3", out_beats); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL multi_overflow: got %0b want 0", out_overflow); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        drive_beat(4'd3, 4'b0001, 4'd2, 4'b1001, 1'b1);
        in_valid = 1'b0;
        wait_valid(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", lat); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: cycle %0d got %0b want 1", c, out_valid); end
            checks++; if ($signed(out_data) !== 20'sd2) begin errors++; $display("FAIL bp_hold_data: cycle %0d got %0d want 2", c, $signed(out_data)); end
            checks++; if (out_beats !== 16'd1) begin errors++; $display("FAIL bp_hold_beats: cycle %0d got %0d want 1", c, out_beats); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %0b want 0", c, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_saturate();
        int lat;
        logic [ACC_S-1:0] exp_s;
        logic             exp_ovf;
`ifdef POT_SHIFT_MAC_SATURATE_EN
        exp_s = 12'h7FF; exp_ovf = 1'b1;
`else
        exp_s = 12'hF00; exp_ovf = 1'b0;
`endif
        drive_beat(4'd15, 4'b0111, 4'd15, 4'b0111, 1'b1);
        in_valid = 1'b0;
        wait_valid(lat);
        checks++; if ($signed(out_data) !== 20'sd3840) begin errors++; $display("FAIL sat_wide_data: got %0d want 3840", $signed(out_data)); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL sat_wide_overflow: got %0b want 0", out_overflow); end
        checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL sat_narrow_valid: got %0b want 1", s_out_valid); end
        checks++; if (s_out_data !== exp_s) begin errors++; $display("FAIL sat_narrow_data: got %0d want %0d", $signed(s_out_data), $signed(exp_s)); end
        checks++; if (s_out_overflow !== exp_ovf) begin errors++; $display("FAIL sat_narrow_overflow: got %0b want %0b", s_out_overflow, exp_ovf); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_vector();
        int lat;
        bit seen;
        drive_beat(4'd9, 4'b0010, 4'd4, 4'b0001, 1'b0);
        drive_beat(4'd7, 4'b0000, 4'd3, 4'b1000, 1'b0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL midrst_out_data: got %0d want 0", out_data); end
        checks++; if (out_beats !== 16'd0) begin errors++; $display("FAIL midrst_out_beats: got %0d want 0", out_beats); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_valid: out_valid seen=%0b want 0", seen); end
        drive_beat(4'd1, 4'b0000, 4'd0, 4'b0000, 1'b1);
        in_valid = 1'b0;
        wait_valid(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL midrst_latency: got %0d want 3", lat); end
        checks++; if ($signed(out_data) !== 20'sd1) begin errors++; $display("FAIL midrst_data: got %0d want 1", $signed(out_data)); end
        checks++; if (out_beats !== 16'd1) begin errors++; $display("FAIL midrst_beats: got %0d want 1", out_beats); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] a0_v [6] = '{4'd1, 4'd2, 4'd7, 4'd1, 4'd1, 4'd4};
        logic [3:0] w0_v [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0010};
        logic       l_v  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic signed [19:0] exp_d [3] = '{20'sd3, 20'sd7, 20'sd16};
        logic [15:0]        exp_b [3] = '{16'd2, 16'd1, 16'd3};
        int got;
        out_ready = 1'b1;
        got = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    drive_beat(a0_v[i], w0_v[i], 4'd0, 4'b0000, l_v[i]);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 300 && got < 3; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        checks++; if ($signed(out_data) !== exp_d[got]) begin errors++; $display("FAIL b2b_data[%0d]: got %0d want %0d", got, $signed(out_data), exp_d[got]); end
                        checks++; if (out_beats !== exp_b[got]) begin errors++; $display("FAIL b2b_beats[%0d]: got %0d want %0d", got, out_beats, exp_b[got]); end
                        got++;
                    end
                end
            end
        join
        checks++; if (got !== 3) begin errors++; $display("FAIL b2b_count: got %0d results want 3", got); end
        repeat (5) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_valid: got %0b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_backpressure();
        test_saturate();
        test_reset_mid_vector();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
